// File: rtl/tl_crossing_arbiter_if.sv
// Bundle of client A/D channels, crossing enq/deq channels and drain control
// for tl_crossing_arbiter. slave = arbiter view, master = environment view.
interface tl_crossing_arbiter_if #(parameter int DEPTH = 4);
  localparam int W = $clog2(DEPTH);

  logic        c0_a_valid, c0_a_ready, c1_a_valid, c1_a_ready;
  logic [2:0]  c0_a_opcode, c1_a_opcode;
  logic [8:0]  c0_a_address, c1_a_address;
  logic [31:0] c0_a_data, c1_a_data;

  logic        out_a_valid, out_a_ready;
  logic [2:0]  out_a_opcode;
  logic [8:0]  out_a_address;
  logic [31:0] out_a_data;

  logic        out_d_valid, out_d_ready, out_d_denied;
  logic [2:0]  out_d_opcode;
  logic [1:0]  out_d_size;
  logic [31:0] out_d_data;

  logic        c0_d_valid, c0_d_ready, c0_d_denied, c1_d_valid, c1_d_ready, c1_d_denied;
  logic [2:0]  c0_d_opcode, c1_d_opcode;
  logic [1:0]  c0_d_size, c1_d_size;
  logic [31:0] c0_d_data, c1_d_data;

  logic        quiesce_req, quiesce_ack;
  logic [W:0]  inflight;

  modport slave (
    input  c0_a_valid, c0_a_opcode, c0_a_address, c0_a_data,
           c1_a_valid, c1_a_opcode, c1_a_address, c1_a_data,
           out_a_ready, out_d_valid, out_d_opcode, out_d_size, out_d_denied, out_d_data,
           c0_d_ready, c1_d_ready, quiesce_req,
    output c0_a_ready, c1_a_ready, out_a_valid, out_a_opcode, out_a_address, out_a_data,
           out_d_ready, c0_d_valid, c0_d_opcode, c0_d_size, c0_d_denied, c0_d_data,
           c1_d_valid, c1_d_opcode, c1_d_size, c1_d_denied, c1_d_data, quiesce_ack, inflight
  );

  modport master (
    output c0_a_valid, c0_a_opcode, c0_a_address, c0_a_data,
           c1_a_valid, c1_a_opcode, c1_a_address, c1_a_data,
           out_a_ready, out_d_valid, out_d_opcode, out_d_size, out_d_denied, out_d_data,
           c0_d_ready, c1_d_ready, quiesce_req,
    input  c0_a_ready, c1_a_ready, out_a_valid, out_a_opcode, out_a_address, out_a_data,
           out_d_ready, c0_d_valid, c0_d_opcode, c0_d_size, c0_d_denied, c0_d_data,
           c1_d_valid, c1_d_opcode, c1_d_size, c1_d_denied, c1_d_data, quiesce_ack, inflight
  );
endinterface

// File: rtl/tl_crossing_arbiter.sv
// Two-client A-channel arbiter in front of a clock crossing, with in-order D routing
// and quiesce/drain control. TL_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module tl_crossing_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  tl_crossing_arbiter_if.slave  bus
);
  localparam int W = $clog2(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, QUIET} state_t;

  state_t         state, state_nxt;
  logic           ack;
  logic           lock_vld, lock_id, lock_nxt;
  logic [W:0]     count, count_nxt;
  logic [W-1:0]   wptr, rptr;
  logic [DEPTH-1:0] ids;
  logic           pick, winner, grant_allowed, full, empty, head;
  logic           a_valid, push, pop, d_ready;

`ifdef TL_ARB_ROUND_ROBIN_EN
  logic rr_ptr;
  // rr_ptr holds the last A-fire winner; the other client wins a tie
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n)  rr_ptr <= 1'b1;
    else if (push) rr_ptr <= winner;
  assign pick = (bus.c0_a_valid && bus.c1_a_valid) ? ~rr_ptr : ~bus.c0_a_valid;
`else
  assign pick = ~bus.c0_a_valid;
`endif

  assign winner        = lock_vld ? lock_id : pick;
  assign full          = (count == (W+1)'(DEPTH));
  assign empty         = (count == '0);
  assign grant_allowed = (state == RUN) || lock_vld;
  assign a_valid       = grant_allowed && (bus.c0_a_valid || bus.c1_a_valid) && !full;
  assign push          = a_valid && bus.out_a_ready;
  assign lock_nxt      = a_valid && !bus.out_a_ready;

  assign bus.out_a_valid   = a_valid;
  assign bus.out_a_opcode  = winner ? bus.c1_a_opcode  : bus.c0_a_opcode;
  assign bus.out_a_address = winner ? bus.c1_a_address : bus.c0_a_address;
  assign bus.out_a_data    = winner ? bus.c1_a_data    : bus.c0_a_data;
  assign bus.c0_a_ready    = push && !winner;
  assign bus.c1_a_ready    = push &&  winner;

  // D beats return in A-fire order, so the FIFO head names the owner
  assign head            = ids[rptr];
  assign d_ready         = !empty && (head ? bus.c1_d_ready : bus.c0_d_ready);
  assign pop             = bus.out_d_valid && d_ready;
  assign bus.out_d_ready = d_ready;
  assign bus.c0_d_valid  = bus.out_d_valid && !empty && !head;
  assign bus.c1_d_valid  = bus.out_d_valid && !empty &&  head;

  assign bus.c0_d_opcode = bus.out_d_opcode;
  assign bus.c0_d_size   = bus.out_d_size;
  assign bus.c0_d_denied = bus.out_d_denied;
  assign bus.c0_d_data   = bus.out_d_data;
  assign bus.c1_d_opcode = bus.out_d_opcode;
  assign bus.c1_d_size   = bus.out_d_size;
  assign bus.c1_d_denied = bus.out_d_denied;
  assign bus.c1_d_data   = bus.out_d_data;

  assign count_nxt       = count + {{W{1'b0}}, push} - {{W{1'b0}}, pop};
  assign bus.inflight    = count;
  assign bus.quiesce_ack = ack;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      ids      <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      lock_vld <= 1'b0;
      lock_id  <= 1'b0;
    end else begin
      if (push) begin
        ids[wptr] <= winner;
        wptr      <= wptr + W'(1);
      end
      if (pop) rptr <= rptr + W'(1);
      count    <= count_nxt;
      lock_vld <= lock_nxt;
      if (lock_nxt) lock_id <= winner;
    end

  // Drain completes on the edge that retires the last outstanding ID
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (bus.quiesce_req) state_nxt = DRAIN;
      DRAIN:   if (!bus.quiesce_req) state_nxt = RUN;
               else if (count_nxt == '0 && !lock_nxt) state_nxt = QUIET;
      QUIET:   if (!bus.quiesce_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= RUN;
      ack   <= 1'b0;
    end else begin
      state <= state_nxt;
      ack   <= (state_nxt == QUIET);
    end
endmodule

// File: tb/tb_tl_crossing_arbiter.sv
// Random + directed bench for tl_crossing_arbiter; a queue-based model is
// checked against the DUT every falling edge.
module tb_tl_crossing_arbiter;
  localparam int DEPTH = 4;

  logic clock, reset_n;
  int   n_checks, n_fail;

  tl_crossing_arbiter_if #(.DEPTH(DEPTH)) bus ();
  tl_crossing_arbiter #(.DEPTH(DEPTH)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ordered queue of outstanding client IDs plus lock and drain mode
  int q[$];
  bit m_locked;
  int m_lock_id, m_mode, m_last;  // m_mode: 0 run, 1 drain, 2 quiet

  always @(negedge clock) begin : cmp
    bit v0, v1, oar, odv, oav, odr, full, allowed;
    int win, head;
    if (!reset_n) begin
      q.delete(); m_locked = 0; m_lock_id = 0; m_mode = 0; m_last = 1;
    end
    v0 = bus.c0_a_valid; v1 = bus.c1_a_valid; oar = bus.out_a_ready; odv = bus.out_d_valid;
    allowed = (m_mode == 0) || m_locked;
    full    = (q.size() == DEPTH);
    oav     = allowed && (v0 || v1) && !full;
    if (m_locked) win = m_lock_id;
    else if (v0 && v1) begin
`ifdef TL_ARB_ROUND_ROBIN_EN
      win = 1 - m_last;
`else
      win = 0;
`endif
    end else win = v0 ? 0 : 1;
    head = (q.size() > 0) ? q[0] : -1;
    odr  = (head == 0 && bus.c0_d_ready) || (head == 1 && bus.c1_d_ready);

    check("out_a_valid", bus.out_a_valid, oav);
    check("c0_a_ready", bus.c0_a_ready, oav && oar && win == 0);
    check("c1_a_ready", bus.c1_a_ready, oav && oar && win == 1);
    if (oav) begin
      check("out_a_address", bus.out_a_address, win ? bus.c1_a_address : bus.c0_a_address);
      check("out_a_opcode", bus.out_a_opcode, win ? bus.c1_a_opcode : bus.c0_a_opcode);
      check("out_a_data", bus.out_a_data, win ? bus.c1_a_data : bus.c0_a_data);
    end
    check("c0_d_valid", bus.c0_d_valid, odv && head == 0);
    check("c1_d_valid", bus.c1_d_valid, odv && head == 1);
    check("out_d_ready", bus.out_d_ready, odr);
    check("c0_d_payload", {bus.c0_d_opcode, bus.c0_d_size, bus.c0_d_denied, bus.c0_d_data},
          {bus.out_d_opcode, bus.out_d_size, bus.out_d_denied, bus.out_d_data});
    check("c1_d_payload", {bus.c1_d_opcode, bus.c1_d_size, bus.c1_d_denied, bus.c1_d_data},
          {bus.out_d_opcode, bus.out_d_size, bus.out_d_denied, bus.out_d_data});
    check("inflight", bus.inflight, q.size());
    check("quiesce_ack", bus.quiesce_ack, m_mode == 2);

    if (reset_n) begin
      if (odv && odr) void'(q.pop_front());
      if (oav && oar) begin q.push_back(win); m_last = win; end
      m_locked = oav && !oar;
      if (m_locked) m_lock_id = win;
      case (m_mode)
        0: if (bus.quiesce_req) m_mode = 1;
        1: if (!bus.quiesce_req) m_mode = 0;
           else if (q.size() == 0 && !m_locked) m_mode = 2;
        default: if (!bus.quiesce_req) m_mode = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic idle_inputs();
    bus.c0_a_valid = 0; bus.c1_a_valid = 0; bus.out_a_ready = 0;
    bus.out_d_valid = 0; bus.c0_d_ready = 0; bus.c1_d_ready = 0; bus.quiesce_req = 0;
    bus.c0_a_opcode = 3'd1; bus.c0_a_address = 9'h0A0; bus.c0_a_data = 32'hC0C0_0000;
    bus.c1_a_opcode = 3'd4; bus.c1_a_address = 9'h1B1; bus.c1_a_data = 32'hC1C1_0000;
    bus.out_d_opcode = 3'd1; bus.out_d_size = 2'd2; bus.out_d_denied = 0; bus.out_d_data = '0;
  endtask

  task automatic drain();
    bus.c0_a_valid = 0; bus.c1_a_valid = 0; bus.quiesce_req = 0;
    bus.out_d_valid = 1; bus.c0_d_ready = 1; bus.c1_d_ready = 1;
    for (int k = 0; k < 40 && bus.inflight != 0; k++) step();
    check("drain_done", bus.inflight, 0);
    bus.out_d_valid = 0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    idle_inputs();
    reset_n = 0;
    bus.out_d_valid = 1;
    @(negedge clock);
    check("rst_inflight", bus.inflight, 0);
    check("rst_ack", bus.quiesce_ack, 0);
    check("rst_out_d_ready", bus.out_d_ready, 0);
    check("rst_c0_d_valid", bus.c0_d_valid, 0);
    @(posedge clock); #3 reset_n = 1;
    bus.out_d_valid = 0;
    step();

    // Both clients valid, crossing always ready: fills to DEPTH then stops
    bus.c0_a_valid = 1; bus.c1_a_valid = 1; bus.out_a_ready = 1;
    for (int i = 0; i < 4; i++) begin
      int exp_id;
`ifdef TL_ARB_ROUND_ROBIN_EN
      exp_id = i % 2;
`else
      exp_id = 0;
`endif
      @(negedge clock);
      check("fill_c0_grant", bus.c0_a_ready, exp_id == 0);
      check("fill_c1_grant", bus.c1_a_ready, exp_id == 1);
      check("fill_inflight", bus.inflight, i);
      step();
    end
    @(negedge clock);
    check("fill_full_inflight", bus.inflight, 4);
    check("fill_full_blocks", bus.out_a_valid, 0);
    step();
    drain();

    // Lock: c1 stalled, c0 arrives later but cannot steal the grant
    bus.c1_a_valid = 1; bus.out_a_ready = 0;
    @(negedge clock);
    check("lock_addr_c1", bus.out_a_address, 9'h1B1);
    check("lock_c1_rdy0", bus.c1_a_ready, 0);
    step(); bus.c0_a_valid = 1;
    @(negedge clock);
    check("lock_addr_held", bus.out_a_address, 9'h1B1);
    check("lock_c0_rdy0", bus.c0_a_ready, 0);
    step();
    @(negedge clock);
    check("lock_addr_held3", bus.out_a_address, 9'h1B1);
    step(); bus.out_a_ready = 1;
    @(negedge clock);
    check("lock_fire_c1", bus.c1_a_ready, 1);
    check("lock_fire_c0", bus.c0_a_ready, 0);
    check("lock_fire_addr", bus.out_a_address, 9'h1B1);
    step(); bus.c0_a_valid = 0; bus.c1_a_valid = 0; bus.out_a_ready = 0;
    @(negedge clock);
    check("lock_inflight", bus.inflight, 1);
    step();
    drain();

    // Ordered D routing: issue c0,c1,c0 then return A,B,C
    bus.out_a_ready = 1; bus.c0_a_valid = 1;
    step(); bus.c0_a_valid = 0; bus.c1_a_valid = 1;
    step(); bus.c1_a_valid = 0; bus.c0_a_valid = 1;
    step(); bus.c0_a_valid = 0;
    bus.out_d_valid = 1; bus.out_d_data = 32'hA; bus.c0_d_ready = 1; bus.c1_d_ready = 1;
    @(negedge clock);
    check("ord_inflight3", bus.inflight, 3);
    check("ord_beatA_c0v", bus.c0_d_valid, 1);
    check("ord_beatA_c1v", bus.c1_d_valid, 0);
    check("ord_beatA_data", bus.c0_d_data, 32'hA);
    step(); bus.out_d_data = 32'hB; bus.c1_d_ready = 0;
    @(negedge clock);
    check("ord_beatB_c1v", bus.c1_d_valid, 1);
    check("ord_beatB_c0v", bus.c0_d_valid, 0);
    check("ord_beatB_stall", bus.out_d_ready, 0);
    step();
    @(negedge clock);
    check("ord_stall_rdy", bus.out_d_ready, 0);
    check("ord_stall_inflight", bus.inflight, 2);
    step(); bus.c1_d_ready = 1;
    @(negedge clock);
    check("ord_beatB_go", bus.out_d_ready, 1);
    check("ord_beatB_data", bus.c1_d_data, 32'hB);
    step(); bus.out_d_data = 32'hC;
    @(negedge clock);
    check("ord_beatC_c0v", bus.c0_d_valid, 1);
    check("ord_beatC_data", bus.c0_d_data, 32'hC);
    check("ord_beatC_inflight", bus.inflight, 1);
    step(); bus.out_d_valid = 0;
    @(negedge clock);
    check("ord_empty", bus.inflight, 0);
    step();

    // Quiesce with two outstanding
    bus.out_a_ready = 1; bus.c0_a_valid = 1;
    step(); bus.c0_a_valid = 0; bus.c1_a_valid = 1;
    step(); bus.c1_a_valid = 0; bus.quiesce_req = 1;
    @(negedge clock);
    check("q_inflight2", bus.inflight, 2);
    check("q_ack0", bus.quiesce_ack, 0);
    step(); bus.c0_a_valid = 1;
    @(negedge clock);
    check("q_no_grant", bus.out_a_valid, 0);
    check("q_no_ready", bus.c0_a_ready, 0);
    step(); bus.out_d_valid = 1;
    @(negedge clock);
    check("q_pop1_rdy", bus.out_d_ready, 1);
    step();
    @(negedge clock);
    check("q_ack_still0", bus.quiesce_ack, 0);
    check("q_inflight1", bus.inflight, 1);
    step(); bus.out_d_valid = 0;
    @(negedge clock);
    check("q_ack1", bus.quiesce_ack, 1);
    check("q_quiet_no_grant", bus.out_a_valid, 0);
    step(); bus.quiesce_req = 0;
    @(negedge clock);
    check("q_ack_hold", bus.quiesce_ack, 1);
    step();
    @(negedge clock);
    check("q_ack_drop", bus.quiesce_ack, 0);
    check("q_run_grant", bus.out_a_valid, 1);
    step();
    drain();

    // Asynchronous reset with three outstanding
    bus.out_a_ready = 1; bus.c0_a_valid = 1;
    step(); step(); step(); bus.c0_a_valid = 0;
    @(negedge clock);
    check("r_inflight3", bus.inflight, 3);
    @(posedge clock); #3 reset_n = 0;
    #1;
    check("r_async_inflight", bus.inflight, 0);
    check("r_async_ack", bus.quiesce_ack, 0);
    bus.out_d_valid = 1;
    @(negedge clock);
    check("r_stray_rdy", bus.out_d_ready, 0);
    check("r_stray_c0v", bus.c0_d_valid, 0);
    @(posedge clock); #3 reset_n = 1;
    @(negedge clock);
    check("r_post_stray_rdy", bus.out_d_ready, 0);
    step(); bus.out_d_valid = 0;

    // Random traffic, model checks every cycle
    for (int c = 0; c < 3000; c++) begin
      bus.c0_a_valid   = ($urandom_range(0, 1) == 1);
      bus.c1_a_valid   = ($urandom_range(0, 1) == 1);
      bus.out_a_ready  = ($urandom_range(0, 3) != 0);
      bus.c0_a_opcode  = 3'($urandom);
      bus.c1_a_opcode  = 3'($urandom);
      bus.c0_a_address = 9'($urandom);
      bus.c1_a_address = 9'($urandom);
      bus.c0_a_data    = $urandom;
      bus.c1_a_data    = $urandom;
      bus.out_d_valid  = ($urandom_range(0, 1) == 1);
      bus.out_d_opcode = 3'($urandom);
      bus.out_d_size   = 2'($urandom);
      bus.out_d_denied = ($urandom_range(0, 1) == 1);
      bus.out_d_data   = $urandom;
      bus.c0_d_ready   = ($urandom_range(0, 3) != 0);
      bus.c1_d_ready   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) bus.quiesce_req = ~bus.quiesce_req;
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
